dac_spi_master: RTL and testbench

Synthesizable SPI initiator that drives the two-channel 16-bit audio DAC from the equalizer output path. Each Start strobe latches one stereo sample pair and sends two 24-bit frames, channel A first and then channel B. Each frame is an 8-bit control byte followed by a 16-bit data word, MSB first, with the DAC sampling on SCK rising edges. It sits between the final mixing stage and the DAC pins.

---
 rtl/dac_spi_master.sv | 182 ++++++++++++++++++
 tb/tb_dac_spi_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_master.sv
// SPI initiator for the two-channel 16-bit audio DAC: one Start sends a
// 24-bit frame for channel A, a CS_-high gap, then a 24-bit frame for channel B.
module dac_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [7:0]  CTRL_A  = 8'h00,
  parameter logic [7:0]  CTRL_B  = 8'h01,
  parameter int unsigned GAP_CYC = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] ChanAData,
  input  logic [15:0] ChanBData,
  output logic        Busy,
  output logic        Done,
  output logic        Dropped,
  output logic        SCK,
  output logic        SDO,
  output logic        CS_
);

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned GAP_W   = 16;
  localparam int unsigned BIT_W   = 5;
  localparam int unsigned FRAME_W = 24;

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_A,
    S_GAP,
    S_SHIFT_B,
    S_DONE
  } state_t;

  state_t               r_state, w_state;
  logic [DIV_W-1:0]     r_div, w_div;
  logic [GAP_W-1:0]     r_gap, w_gap;
  logic [BIT_W-1:0]     r_bits, w_bits;
  logic                 r_hold, w_hold;
  logic [FRAME_W-1:0]   r_shift, w_shift;
  logic [FRAME_W-1:0]   r_frame_b, w_frame_b;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 r_dropped, w_dropped;
  logic                 r_sck, w_sck;
  logic                 r_sdo, w_sdo;
  logic                 r_cs_n, w_cs_n;

  // State, divider, shift data and all pin outputs are registered here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_gap     <= '0;
      r_bits    <= '0;
      r_hold    <= 1'b0;
      r_shift   <= '0;
      r_frame_b <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
      r_sck     <= 1'b0;
      r_sdo     <= 1'b0;
      r_cs_n    <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_div     <= w_div;
      r_gap     <= w_gap;
      r_bits    <= w_bits;
      r_hold    <= w_hold;
      r_shift   <= w_shift;
      r_frame_b <= w_frame_b;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_dropped <= w_dropped;
      r_sck     <= w_sck;
      r_sdo     <= w_sdo;
      r_cs_n    <= w_cs_n;
    end
  end

  // Next-state and next-output logic; each SCK phase and the CS_ hold last D cycles.
  always_comb begin
    w_state   = r_state;
    w_div     = r_div;
    w_gap     = r_gap;
    w_bits    = r_bits;
    w_hold    = r_hold;
    w_shift   = r_shift;
    w_frame_b = r_frame_b;
    w_sck     = r_sck;
    w_sdo     = r_sdo;
    w_cs_n    = r_cs_n;
    w_done    = 1'b0;
    w_dropped = Start && r_busy;

    case (r_state)
      S_IDLE, S_DONE: begin
        w_state = S_IDLE;
        w_sck   = 1'b0;
        w_sdo   = 1'b0;
        w_cs_n  = 1'b1;
        if (Start) begin
          w_state   = S_SHIFT_A;
          w_shift   = {CTRL_A, ChanAData};
          w_frame_b = {CTRL_B, ChanBData};
          w_sdo     = CTRL_A[7];
          w_cs_n    = 1'b0;
          w_div     = DIV_RELOAD;
          w_bits    = BIT_LAST;
          w_hold    = 1'b0;
        end
      end

      S_SHIFT_A, S_SHIFT_B: begin
        if (r_div != '0) begin
          w_div = r_div - DIV_W'(1);
        end else if (r_hold) begin
          // Frame complete: release CS_ and park the data line low.
          w_cs_n = 1'b1;
          w_sck  = 1'b0;
          w_sdo  = 1'b0;
          w_hold = 1'b0;
          if (r_state == S_SHIFT_A) begin
            w_state = S_GAP;
            w_gap   = GAP_RELOAD;
          end else begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end
        end else if (!r_sck) begin
          w_sck = 1'b1;
          w_div = DIV_RELOAD;
        end else if (r_bits == '0) begin
          w_sck  = 1'b0;
          w_hold = 1'b1;
          w_div  = DIV_RELOAD;
        end else begin
          // Rotate so the next bit sits at the MSB as SCK returns low.
          w_sck   = 1'b0;
          w_shift = {r_shift[FRAME_W-2:0], r_shift[FRAME_W-1]};
          w_sdo   = r_shift[FRAME_W-2];
          w_bits  = r_bits - BIT_W'(1);
          w_div   = DIV_RELOAD;
        end
      end

      S_GAP: begin
        if (r_gap != '0) begin
          w_gap = r_gap - GAP_W'(1);
        end else begin
          w_state = S_SHIFT_B;
          w_shift = r_frame_b;
          w_sdo   = r_frame_b[FRAME_W-1];
          w_cs_n  = 1'b0;
          w_sck   = 1'b0;
          w_div   = DIV_RELOAD;
          w_bits  = BIT_LAST;
          w_hold  = 1'b0;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy = (w_state == S_SHIFT_A) || (w_state == S_GAP) || (w_state == S_SHIFT_B);
  end

  assign Busy    = r_busy;
  assign Done    = r_done;
  assign Dropped = r_dropped;
  assign SCK     = r_sck;
  assign SDO     = r_sdo;
  assign CS_     = r_cs_n;

endmodule

// File: tb/tb_dac_spi_master.sv
// Bench for dac_spi_master: two instances (D=2/GAP=8 and D=1/GAP=3) share
// stimulus; each is compared every cycle against a timeline model, and an
// SPI monitor reassembles the D=2 instance's frames from SCK rising edges.
module tb_dac_spi_master;

  localparam int D0 = 2;
  localparam int G0 = 8;
  localparam int D1 = 1;
  localparam int G1 = 3;
  localparam logic [7:0] CA = 8'h00;
  localparam logic [7:0] CB = 8'h01;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;

  logic busy0, done0, drop0, sck0, sdo0, cs0;
  logic busy1, done1, drop1, sck1, sdo1, cs1;

  always #5 Clk = ~Clk;

  dac_spi_master #(.CLK_DIV(D0), .CTRL_A(CA), .CTRL_B(CB), .GAP_CYC(G0)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ChanAData(A), .ChanBData(B),
    .Busy(busy0), .Done(done0), .Dropped(drop0), .SCK(sck0), .SDO(sdo0), .CS_(cs0)
  );

  dac_spi_master #(.CLK_DIV(D1), .CTRL_A(CA), .CTRL_B(CB), .GAP_CYC(G1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ChanAData(A), .ChanBData(B),
    .Busy(busy1), .Done(done1), .Dropped(drop1), .SCK(sck1), .SDO(sdo1), .CS_(cs1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference state per instance: transfer active, accept cycle, frame words.
  bit          act[2];
  int          t0[2];
  logic [23:0] wa[2];
  logic [23:0] wb[2];
  bit          dn[2];
  logic [23:0] spi_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic int dd(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int gg(input int i);
    return (i == 0) ? G0 : G1;
  endfunction

  // Expected {CS_, SCK, SDO, Busy, Done} at the current cycle from the frame timeline.
  function automatic logic [4:0] exp_out(input int i);
    int t, d, g, u;
    logic [23:0] w;
    if (!act[i]) return 5'b10000;
    d = dd(i);
    g = gg(i);
    t = cyc - t0[i];
    if (t >= 1 && t <= 49*d) begin
      u = t - 1;
      w = wa[i];
    end else if (t > 49*d && t <= 49*d + g) begin
      return 5'b10010;
    end else if (t > 49*d + g && t <= 98*d + g) begin
      u = t - 1 - 49*d - g;
      w = wb[i];
    end else if (t == 98*d + g + 1) begin
      return 5'b10001;
    end else begin
      return 5'b10000;
    end
    if (u < 48*d) return {1'b0, 1'((u % (2*d)) >= d), w[23 - u/(2*d)], 1'b1, 1'b0};
    return {1'b0, 1'b0, w[0], 1'b1, 1'b0};
  endfunction

  // Advance the model by the current inputs, clock once, compare both instances.
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      int t;
      bit bz;
      t  = cyc - t0[i];
      bz = act[i] && (t >= 1) && (t <= 98*dd(i) + gg(i));
      if (Reset) begin
        act[i] = 1'b0;
        dn[i]  = 1'b0;
      end else begin
        dn[i] = Start && bz;
        if (Start && !bz) begin
          act[i] = 1'b1;
          t0[i]  = cyc;
          wa[i]  = {CA, A};
          wb[i]  = {CB, B};
          if (i == 0) begin
            spi_q.push_back({CA, A});
            spi_q.push_back({CB, B});
          end
        end
      end
    end
    @(posedge Clk);
    cyc++;
    #1;
    chk("pins_d2", {26'd0, cs0, sck0, sdo0, busy0, done0, drop0}, {26'd0, exp_out(0), dn[0]});
    chk("pins_d1", {26'd0, cs1, sck1, sdo1, busy1, done1, drop1}, {26'd0, exp_out(1), dn[1]});
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    Start = 1'b1;
    A = a;
    B = b;
    tick();
    Start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
  endtask

  // SPI monitor on the D=2 instance: collect SDO at each SCK rise inside a CS_ window.
  int          mon_n = 0;
  logic [23:0] mon_w = '0;
  logic [23:0] mon_e;

  always @(negedge cs0) begin
    mon_n = 0;
    mon_w = '0;
  end

  always @(posedge sck0) begin
    if (cs0 === 1'b0) begin
      mon_w = {mon_w[22:0], sdo0};
      mon_n++;
    end
  end

  always @(posedge cs0) begin
    if (Reset === 1'b0) begin
      if (spi_q.size() == 0) begin
        chk("spi_unexpected_frame", 32'd1, 32'd0);
      end else begin
        mon_e = spi_q.pop_front();
        chk("spi_bits", 32'(mon_n), 32'd24);
        chk("spi_word", {8'd0, mon_w}, {8'd0, mon_e});
      end
    end
  end

  // Abandoned transfers leave nothing for the monitor to match.
  always @(posedge Clk) begin
    if (Reset === 1'b1) spi_q.delete();
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0;
      t0[i]  = 0;
      wa[i]  = '0;
      wb[i]  = '0;
      dn[i]  = 1'b0;
    end

    repeat (3) tick();
    Reset = 1'b0;
    repeat (100) tick();

    send(16'hA5C3, 16'h1234);
    repeat (220) tick();

    send(16'hFFFF, 16'h0000);
    repeat (220) tick();

    // Second Start ten cycles into a transfer must only produce Dropped.
    send(16'h5A5A, 16'hC0DE);
    repeat (9) tick();
    Start = 1'b1;
    A = 16'h1111;
    B = 16'h2222;
    tick();
    Start = 1'b0;
    repeat (210) tick();

    // Back-to-back: next Start lands on the Done cycle.
    send(16'h0F0F, 16'hF0F0);
    repeat (204) tick();
    chk("done_at_n205", {31'd0, done0}, 32'd1);
    send(16'h8001, 16'h7FFE);
    repeat (220) tick();

    // Reset after the 12th SCK rising edge of frame A, then a clean transfer.
    send(16'hDEAD, 16'hBEEF);
    repeat (47) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (5) tick();
    send(16'h3C3C, 16'h4D4D);
    repeat (220) tick();

    // Random traffic with random data every cycle and rare resets.
    for (int k = 0; k < 3000; k++) begin
      Start = ($urandom_range(0, 59) == 0);
      Reset = ($urandom_range(0, 1499) == 0);
      A = 16'($urandom);
      B = 16'($urandom);
      tick();
    end
    Start = 1'b0;
    Reset = 1'b0;
    repeat (220) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
